// File: rtl/serdesphy_rx_deserializer_pkg.sv
// Shared constants and types for the serdesphy receive path
// (deserializer and Manchester decoder).
package serdesphy_rx_pkg;

  localparam int          WORD_W             = 16;
  localparam logic [15:0] DEFAULT_SYNC_WORD  = 16'h5999;
  localparam int          DEFAULT_ERR_THRESH = 2;

  typedef enum logic [1:0] {
    RX_HUNT   = 2'b00,
    RX_LOCKED = 2'b01
  } rx_state_e;

  // A Manchester pair {w[2i+1], w[2i]} is legal only as 10 or 01.
  function automatic logic has_invalid_pair(input logic [WORD_W-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < WORD_W / 2; i++) begin
      if (w[2*i+1] == w[2*i]) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/serdesphy_rx_deserializer_pair_check.sv
// Combinational Manchester pair validity check over one 16-bit word.
// Flags the word when any symbol pair is 00 or 11.
module serdesphy_manchester_pair_check
  import serdesphy_rx_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              invalid_pair
);

  // Reduce all pairs of the word into a single invalid flag.
  always_comb begin
    invalid_pair = has_invalid_pair(word);
  end

endmodule

// File: rtl/serdesphy_rx_deserializer.sv
// Receive-path deserializer: shifts recovered half-bit symbols into a
// 16-bit register, hunts for the Manchester sync word, then emits aligned
// words with a one-cycle data_valid strobe. Persistent invalid pairs drop lock.
module serdesphy_rx_deserializer
  import serdesphy_rx_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
  parameter int                ERR_THRESH = DEFAULT_ERR_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_data,
  input  logic              serial_valid,
  input  logic              align_enable,
  output logic [WORD_W-1:0] manchester_data,
  output logic              data_valid,
  output logic              locked,
  output logic              sync_detect,
  output logic              lock_lost
);

  localparam logic [2:0] ERR_THRESH_C = 3'(ERR_THRESH);

  rx_state_e         state_r;
  logic [WORD_W-1:0] shreg_r;
  logic [3:0]        bit_cnt_r;
  logic [2:0]        err_cnt_r;
  logic [WORD_W-1:0] manchester_data_r;
  logic              data_valid_r;
  logic              locked_r;
  logic              sync_detect_r;
  logic              lock_lost_r;

  logic [WORD_W-1:0] next_word_s;
  logic              word_bad_s;

  // Word as it will look once the current symbol is shifted in.
  always_comb begin
    next_word_s = {shreg_r[WORD_W-2:0], serial_data};
  end

  serdesphy_manchester_pair_check u_pair_check (
    .word         (next_word_s),
    .invalid_pair (word_bad_s)
  );

  // Alignment FSM, shift register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= RX_HUNT;
      shreg_r           <= '0;
      bit_cnt_r         <= 4'd0;
      err_cnt_r         <= 3'd0;
      manchester_data_r <= '0;
      data_valid_r      <= 1'b0;
      locked_r          <= 1'b0;
      sync_detect_r     <= 1'b0;
      lock_lost_r       <= 1'b0;
    end else if (!align_enable) begin
      // Disabled alignment is a quiet drop: no lock_lost pulse.
      state_r       <= RX_HUNT;
      shreg_r       <= '0;
      bit_cnt_r     <= 4'd0;
      err_cnt_r     <= 3'd0;
      data_valid_r  <= 1'b0;
      locked_r      <= 1'b0;
      sync_detect_r <= 1'b0;
      lock_lost_r   <= 1'b0;
    end else begin
      data_valid_r  <= 1'b0;
      sync_detect_r <= 1'b0;
      lock_lost_r   <= 1'b0;
      if (serial_valid) begin
        shreg_r <= next_word_s;
        case (state_r)
          RX_HUNT: begin
            if (next_word_s == SYNC_WORD) begin
              state_r       <= RX_LOCKED;
              bit_cnt_r     <= 4'd0;
              sync_detect_r <= 1'b1;
              locked_r      <= 1'b1;
            end
          end
          RX_LOCKED: begin
            if (bit_cnt_r == 4'd15) begin
              // Bad words are still delivered; the decoder flags them.
              manchester_data_r <= next_word_s;
              data_valid_r      <= 1'b1;
              bit_cnt_r         <= 4'd0;
              if (word_bad_s) begin
                if ((err_cnt_r + 3'd1) >= ERR_THRESH_C) begin
                  // Shift register is kept so a sync already in flight is caught.
                  state_r     <= RX_HUNT;
                  locked_r    <= 1'b0;
                  lock_lost_r <= 1'b1;
                  err_cnt_r   <= 3'd0;
                end else begin
                  err_cnt_r <= err_cnt_r + 3'd1;
                end
              end else begin
                err_cnt_r <= 3'd0;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          default: begin
            state_r  <= RX_HUNT;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign manchester_data = manchester_data_r;
  assign data_valid      = data_valid_r;
  assign locked          = locked_r;
  assign sync_detect     = sync_detect_r;
  assign lock_lost       = lock_lost_r;

endmodule

// File: tb/tb_serdesphy_rx_deserializer.sv
// Self-checking bench for serdesphy_rx_deserializer: a table of words
// streamed one symbol per 4 clocks, plus hand sequences for slip,
// align_enable drop and reset mid-word.
module tb_serdesphy_rx_deserializer;

  logic        clk;
  logic        rst;
  logic        serial_data;
  logic        serial_valid;
  logic        align_enable;
  logic [15:0] manchester_data;
  logic        data_valid;
  logic        locked;
  logic        sync_detect;
  logic        lock_lost;

  serdesphy_rx_deserializer dut (
    .clk             (clk),
    .rst             (rst),
    .serial_data     (serial_data),
    .serial_valid    (serial_valid),
    .align_enable    (align_enable),
    .manchester_data (manchester_data),
    .data_valid      (data_valid),
    .locked          (locked),
    .sync_detect     (sync_detect),
    .lock_lost       (lock_lost)
  );

  initial clk = 1'b0;
  always #21 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Pulse monitor, sampled on the falling edge.
  int          dv_cnt   = 0;
  int          sync_cnt = 0;
  int          lost_cnt = 0;
  logic [15:0] last_data = 16'h0000;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt    = dv_cnt + 1;
      last_data = manchester_data;
    end
    if (sync_detect) sync_cnt = sync_cnt + 1;
    if (lock_lost)   lost_cnt = lost_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    chk_cnt = chk_cnt + 1;
    if (act == exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One symbol: valid for one clock, then three idle clocks. Called at negedge.
  task automatic send_bit(input logic b);
    serial_data  = b;
    serial_valid = 1'b1;
    @(negedge clk);
    serial_valid = 1'b0;
    serial_data  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0] word;
    logic        exp_dv;
    logic [15:0] exp_data;
    logic        exp_sync;
    logic        exp_lost;
    logic        exp_locked;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int dv0, sync0, lost0;

  initial begin
    // word, dv, data, sync, lost, locked
    vecs[0] = '{16'h5999, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1}; // sync, not output
    vecs[1] = '{16'h5A66, 1'b1, 16'h5A66, 1'b0, 1'b0, 1'b1}; // good word
    vecs[2] = '{16'h5A67, 1'b1, 16'h5A67, 1'b0, 1'b0, 1'b1}; // bad, err=1
    vecs[3] = '{16'h5999, 1'b1, 16'h5999, 1'b0, 1'b0, 1'b1}; // good, err clears
    vecs[4] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1}; // bad, err=1
    vecs[5] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0}; // bad, err=2 -> lost
    vecs[6] = '{16'h5A66, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}; // hunting, no output
    vecs[7] = '{16'h5999, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1}; // relock
    vecs[8] = '{16'h5A66, 1'b1, 16'h5A66, 1'b0, 1'b0, 1'b1};

    rst          = 1'b1;
    serial_data  = 1'b0;
    serial_valid = 1'b0;
    align_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset data",        int'(manchester_data), 0);
    check("reset data_valid",  int'(data_valid), 0);
    check("reset locked",      int'(locked), 0);
    check("reset sync_detect", int'(sync_detect), 0);
    check("reset lock_lost",   int'(lock_lost), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven stream.
    for (int v = 0; v < NVEC; v++) begin
      dv0 = dv_cnt; sync0 = sync_cnt; lost0 = lost_cnt;
      send_bits(vecs[v].word, 15, 0);
      check($sformatf("vec%0d data_valid count", v), dv_cnt - dv0, int'(vecs[v].exp_dv));
      check($sformatf("vec%0d sync_detect count", v), sync_cnt - sync0, int'(vecs[v].exp_sync));
      check($sformatf("vec%0d lock_lost count", v), lost_cnt - lost0, int'(vecs[v].exp_lost));
      check($sformatf("vec%0d locked", v), int'(locked), int'(vecs[v].exp_locked));
      if (vecs[v].exp_dv) begin
        check($sformatf("vec%0d data", v), int'(last_data), int'(vecs[v].exp_data));
      end
    end

    // Slipped stream: three junk symbols ahead of the sync word.
    do_reset(2);
    dv0 = dv_cnt; sync0 = sync_cnt;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bits(16'h5999, 15, 0);
    check("slip sync_detect count", sync_cnt - sync0, 1);
    check("slip locked", int'(locked), 1);
    check("slip no dv for sync", dv_cnt - dv0, 0);
    send_bits(16'h6996, 15, 0);
    check("slip dv count", dv_cnt - dv0, 1);
    check("slip data", int'(last_data), 16'h6996);

    // align_enable drop after 7 locked symbols.
    dv0 = dv_cnt; sync0 = sync_cnt; lost0 = lost_cnt;
    send_bits(16'h5A66, 15, 9);
    align_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("align drop locked", int'(locked), 0);
    align_enable = 1'b1;
    @(negedge clk);
    check("align drop no dv", dv_cnt - dv0, 0);
    check("align drop no lost", lost_cnt - lost0, 0);
    send_bits(16'h5999, 15, 0);
    check("align relock sync", sync_cnt - sync0, 1);
    check("align relock locked", int'(locked), 1);
    send_bits(16'h5A66, 15, 0);
    check("align relock dv", dv_cnt - dv0, 1);
    check("align relock data", int'(last_data), 16'h5A66);

    // Reset after 9 locked symbols.
    dv0 = dv_cnt; sync0 = sync_cnt; lost0 = lost_cnt;
    send_bits(16'h5A66, 15, 7);
    rst = 1'b1;
    @(negedge clk);
    check("midrst data",        int'(manchester_data), 0);
    check("midrst data_valid",  int'(data_valid), 0);
    check("midrst locked",      int'(locked), 0);
    check("midrst sync_detect", int'(sync_detect), 0);
    check("midrst lock_lost",   int'(lock_lost), 0);
    rst = 1'b0;
    @(negedge clk);
    send_bits(16'h5A66, 6, 0);
    check("midrst no dv", dv_cnt - dv0, 0);
    check("midrst still hunting", int'(locked), 0);
    check("midrst no lost", lost_cnt - lost0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serdesphy_rx_deserializer.md
Name: serdesphy_rx_deserializer

Overview:
- Receive-path stage between the CDR/sampler output and the Manchester decoder.
- Shifts recovered serial half-bit symbols into a 16-bit register and hunts for a Manchester-encoded sync word to establish word alignment.
- Once locked, emits aligned 16-bit Manchester words with a one-cycle data_valid strobe, which the decoder consumes directly.
- Monitors invalid symbol pairs and drops lock on persistent misalignment.

Parameters:
- SYNC_WORD, 16'h5999, Manchester encoding of decoded byte 8'hD5, used as the alignment marker.
- ERR_THRESH, 2, consecutive words containing an invalid pair that force loss of lock (legal range 1..7).

Ports:
- clk  input  1  24 MHz system clock.
- rst  input  1  synchronous active-high reset.
- serial_data  input  1  recovered half-bit symbol.
- serial_valid  input  1  strobe; serial_data is sampled on clk edges where this is 1.
- align_enable  input  1  0 holds the block in HUNT with the shift register cleared.
- manchester_data  output  16  aligned Manchester word; bit 15 is the first received symbol.
- data_valid  output  1  one-cycle strobe marking a new manchester_data.
- locked  output  1  1 while in LOCKED.
- sync_detect  output  1  one-cycle pulse on SYNC_WORD match in HUNT.
- lock_lost  output  1  one-cycle pulse on the LOCKED to HUNT transition caused by errors.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: every output is 0; shift register is 0; bit counter is 0; error counter is 0; state is HUNT.
- Reset asserted mid-word discards the partial word and produces no data_valid.
- Shift rule: on each edge with serial_valid=1, shreg <= {shreg[14:0], serial_data}. The first half-bit of each pair therefore lands at the odd index, matching the decoder (10 = logic 0, 01 = logic 1).
- States: HUNT, LOCKED (2-bit encoding, default arm returns to HUNT).
- HUNT:
  - On a sampled bit where {shreg[14:0], serial_data} == SYNC_WORD: go to LOCKED, clear bit_cnt, pulse sync_detect the next cycle.
  - The sync word itself is never output and no data_valid is produced.
- LOCKED:
  - bit_cnt (4 bits) increments on each sampled bit.
  - On the sample where bit_cnt==15: manchester_data <= {shreg[14:0], serial_data}, data_valid <= 1 for exactly one cycle, bit_cnt wraps to 0.
  - Latency: data_valid and the new word are visible the cycle after the 16th sampling edge.
- Pair check (combinational, on the captured word): a word is bad if any pair {w[2i+1], w[2i]} is 00 or 11.
  - Bad word: err_cnt increments. On reaching ERR_THRESH: state goes to HUNT, locked drops, lock_lost pulses one cycle, err_cnt clears.
  - Good word: err_cnt clears.
  - The bad word is still emitted with data_valid; the decoder flags it.
- After losing lock, hunting restarts from the current shreg contents. The shift register is not cleared, so a sync already in flight can be caught.
- align_enable=0 takes priority over everything except rst: state=HUNT, shreg, bit_cnt and err_cnt clear, locked=0. It produces no lock_lost pulse.
- serial_valid gaps of any length pause the counters. There is no timeout.
- Rate rule: serial_valid must be asserted at most once per 4 clk cycles, so a word arrives no faster than every 64 clk cycles and the 4-cycle decoder handshake is never overrun. This block does not check the rule.
- locked is registered and asserts the same cycle as the sync_detect pulse.

Decomposition:
- Package serdesphy_rx_pkg: WORD_W=16, default SYNC_WORD, RX_HUNT/RX_LOCKED state constants, DEFAULT_ERR_THRESH. The decoder shares these.
- Sub-module serdesphy_manchester_pair_check: combinational, 16-bit input, 1-bit invalid-pair output. The decoder reuses it later.

Test Plan:
- Reset then sync: rst held 2 cycles, then serial stream 0x5999 followed by word 0x5A66, one bit per 4 clk -> sync_detect pulse and locked=1 after bit 16; exactly one data_valid with manchester_data=16'h5A66; no data_valid for the sync word.
- Slipped stream: sync preceded by 3 junk half-bits (1,1,0) -> alignment still found at the sync boundary; next word is output correctly.
- Loss of lock: locked, send 0x5A66, then 0xFFFF and 0x0000 -> two data_valid with bad words; lock_lost pulse with locked=0 on the second; third word produces no data_valid.
- Error recovery: bad word 0x5A67, then good word 0x5999 -> err_cnt clears, locked stays 1, both words output.
- align_enable drop: deassert mid-word after 7 bits -> locked=0, no data_valid, no lock_lost; re-enable plus sync relocks.
- Reset mid-word: rst asserted after 9 locked bits -> all outputs 0 next cycle; no data_valid for the partial word.
